// File: rtl/es_pkg.sv
// es_pkg: shared FSM state type, default sizes and a small helper for the entradaSalida arbiter.
package es_pkg;

    localparam int unsigned DATA_W_DEF        = 8;
    localparam int unsigned ADDR_W_DEF        = 7;
    localparam int unsigned NUM_DISP_DEF      = 5;
    localparam int unsigned ACCESS_CYCLES_DEF = 2;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS,
        DONE
    } es_state_e;

    // Requester index that did not receive the previous grant.
    function automatic logic otro_puerto(input logic puerto);
        return ~puerto;
    endfunction

endpackage

// File: rtl/rr_arbitro_2.sv
// rr_arbitro_2: combinational two-way picker (grant index). Round-robin by default;
// ES_PRIORIDAD_FIJA_EN selects fixed priority where req0 always wins a tie.
module rr_arbitro_2
    import es_pkg::*;
(
    input  logic req0,
    input  logic req1,
    input  logic last_grant,
    output logic grant
);

`ifdef ES_PRIORIDAD_FIJA_EN
    logic unused_last_grant;
    assign unused_last_grant = last_grant;

    always_comb begin
        grant = 1'b0;
        if (!req0 && req1) begin
            grant = 1'b1;
        end
    end
`else
    always_comb begin
        grant = 1'b0;
        if (req0 && req1) begin
            grant = otro_puerto(last_grant);
        end else if (req1) begin
            grant = 1'b1;
        end
    end
`endif

endmodule

// File: rtl/arbitro_entrada_salida.sv
// arbitro_entrada_salida: shares the entradaSalida I/O block between two requesters,
// one latched transaction at a time. ES_PRIORIDAD_FIJA_EN selects fixed priority arbitration.
module arbitro_entrada_salida
    import es_pkg::*;
#(
    parameter int unsigned DATA_W        = DATA_W_DEF,
    parameter int unsigned ADDR_W        = ADDR_W_DEF,
    parameter int unsigned NUM_DISP      = NUM_DISP_DEF,
    parameter int unsigned ACCESS_CYCLES = ACCESS_CYCLES_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req0,
    input  logic              req1,
    input  logic              we0,
    input  logic              we1,
    input  logic [ADDR_W-1:0] dir0,
    input  logic [ADDR_W-1:0] dir1,
    input  logic [DATA_W-1:0] dato0,
    input  logic [DATA_W-1:0] dato1,
    output logic              ack0,
    output logic              ack1,
    output logic              err0,
    output logic              err1,
    output logic [DATA_W-1:0] rdata0,
    output logic [DATA_W-1:0] rdata1,
    output logic              busy,
    output logic              activarEntradaSalida,
    output logic              escribirEntradaSalida,
    output logic [ADDR_W-1:0] direccionEntradaSalida,
    output logic [DATA_W-1:0] entradaEntradaSalida,
    input  logic [DATA_W-1:0] salidaEntradaSalida
);

    localparam int unsigned     CNT_W      = $clog2(ACCESS_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_CARGA = CNT_W'(ACCESS_CYCLES);
    localparam logic [CNT_W-1:0] CNT_UNO   = CNT_W'(1);
    localparam logic [ADDR_W:0]  LIMITE_DIR = (ADDR_W + 1)'(NUM_DISP);

    es_state_e         estado_q, estado_d;
    logic [CNT_W-1:0]  cnt_q;
    logic              ganador_q;
    logic              we_q;
    logic              err_q;
    logic [ADDR_W-1:0] dir_q;
    logic [DATA_W-1:0] dato_q;
    logic [DATA_W-1:0] rdata0_q, rdata1_q;

    logic              grant;
    logic              last_grant;
    logic              sel_we;
    logic [ADDR_W-1:0] sel_dir;
    logic [DATA_W-1:0] sel_dato;
    logic              sel_fuera;
    logic              alguna_req;
    logic              bus_activo;

    rr_arbitro_2 u_arbitro (
        .req0       (req0),
        .req1       (req1),
        .last_grant (last_grant),
        .grant      (grant)
    );

    assign alguna_req = req0 | req1;
    assign sel_we     = grant ? we1 : we0;
    assign sel_dir    = grant ? dir1 : dir0;
    assign sel_dato   = grant ? dato1 : dato0;
    assign sel_fuera  = {1'b0, sel_dir} >= LIMITE_DIR;

`ifdef ES_PRIORIDAD_FIJA_EN
    assign last_grant = 1'b0;
`else
    logic last_grant_q;

    // Reset value 1 lets requester 0 win the first tie.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_grant_q <= 1'b1;
        end else if (estado_q == DONE) begin
            last_grant_q <= ganador_q;
        end
    end

    assign last_grant = last_grant_q;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            estado_q <= IDLE;
        end else begin
            estado_q <= estado_d;
        end
    end

    always_comb begin
        estado_d = estado_q;
        case (estado_q)
            IDLE:    if (alguna_req) estado_d = SETUP;
            SETUP:   estado_d = err_q ? DONE : ACCESS;
            ACCESS:  if (cnt_q == CNT_UNO) estado_d = DONE;
            DONE:    estado_d = IDLE;
            default: estado_d = IDLE;
        endcase
    end

    // Transaction latch, access counter and read-data capture.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q     <= '0;
            ganador_q <= 1'b0;
            we_q      <= 1'b0;
            err_q     <= 1'b0;
            dir_q     <= '0;
            dato_q    <= '0;
            rdata0_q  <= '0;
            rdata1_q  <= '0;
        end else begin
            case (estado_q)
                IDLE: begin
                    if (alguna_req) begin
                        ganador_q <= grant;
                        we_q      <= sel_we;
                        dir_q     <= sel_dir;
                        dato_q    <= sel_dato;
                        err_q     <= sel_fuera;
                    end
                end
                SETUP: begin
                    if (!err_q) begin
                        cnt_q <= CNT_CARGA;
                    end else if (!we_q) begin
                        if (ganador_q) rdata1_q <= '0;
                        else           rdata0_q <= '0;
                    end
                end
                ACCESS: begin
                    cnt_q <= cnt_q - CNT_UNO;
                    if (cnt_q == CNT_UNO && !we_q) begin
                        if (ganador_q) rdata1_q <= salidaEntradaSalida;
                        else           rdata0_q <= salidaEntradaSalida;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Bus is driven only in SETUP and ACCESS so the I/O block never sees a stale address.
    always_comb begin
        bus_activo             = (estado_q == SETUP) || (estado_q == ACCESS);
        busy                   = estado_q != IDLE;
        activarEntradaSalida   = estado_q == ACCESS;
        escribirEntradaSalida  = bus_activo & we_q;
        direccionEntradaSalida = bus_activo ? dir_q : '0;
        entradaEntradaSalida   = (bus_activo && we_q) ? dato_q : '0;
        ack0                   = (estado_q == DONE) && !ganador_q;
        ack1                   = (estado_q == DONE) && ganador_q;
        err0                   = ack0 & err_q;
        err1                   = ack1 & err_q;
    end

    assign rdata0 = rdata0_q;
    assign rdata1 = rdata1_q;

endmodule

// File: tb/tb_arbitro_entrada_salida.sv
// Scoreboard bench for arbitro_entrada_salida: a transaction-level model pushes expected
// acknowledges, a monitor pops them and also checks the I/O bus every cycle.
module tb_arbitro_entrada_salida;

    localparam int DW = 8;
    localparam int AW = 7;
    localparam int ND = 5;
    localparam int AC = 2;

    logic          clk   = 1'b0;
    logic          reset = 1'b1;
    logic          req0  = 1'b0, req1 = 1'b0, we0 = 1'b0, we1 = 1'b0;
    logic [AW-1:0] dir0  = '0, dir1 = '0;
    logic [DW-1:0] dato0 = '0, dato1 = '0;
    logic          ack0, ack1, err0, err1, busy, activar, escribir;
    logic [DW-1:0] rdata0, rdata1, entrada, salida;
    logic [AW-1:0] direccion;
    logic [DW-1:0] io_mem [128];

    assign salida = io_mem[direccion];

    arbitro_entrada_salida #(
        .DATA_W        (DW),
        .ADDR_W        (AW),
        .NUM_DISP      (ND),
        .ACCESS_CYCLES (AC)
    ) dut (
        .clk                    (clk),
        .reset                  (reset),
        .req0                   (req0),
        .req1                   (req1),
        .we0                    (we0),
        .we1                    (we1),
        .dir0                   (dir0),
        .dir1                   (dir1),
        .dato0                  (dato0),
        .dato1                  (dato1),
        .ack0                   (ack0),
        .ack1                   (ack1),
        .err0                   (err0),
        .err1                   (err1),
        .rdata0                 (rdata0),
        .rdata1                 (rdata1),
        .busy                   (busy),
        .activarEntradaSalida   (activar),
        .escribirEntradaSalida  (escribir),
        .direccionEntradaSalida (direccion),
        .entradaEntradaSalida   (entrada),
        .salidaEntradaSalida    (salida)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int nvec  = 0;
    int nfail = 0;

    typedef struct {
        bit            port;
        bit            we;
        bit            err;
        logic [AW-1:0] dir;
        logic [DW-1:0] dato;
        int            start;
        int            ack_cyc;
        logic [DW-1:0] rd0;
        logic [DW-1:0] rd1;
    } tx_t;

    tx_t           exp_q0[$];
    tx_t           exp_q1[$];
    tx_t           cur;
    bit            cur_valid = 1'b0;
    int            m_free    = 0;
    bit            m_last    = 1'b1;
    logic [DW-1:0] m_rd [2]  = '{8'h00, 8'h00};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_activar"}, activar, 0);
        chk({tag, "_escribir"}, escribir, 0);
        chk({tag, "_direccion"}, direccion, 0);
        chk({tag, "_entrada"}, entrada, 0);
        chk({tag, "_ack0"}, ack0, 0);
        chk({tag, "_ack1"}, ack1, 0);
        chk({tag, "_err0"}, err0, 0);
        chk({tag, "_err1"}, err1, 0);
        chk({tag, "_rdata0"}, rdata0, 0);
        chk({tag, "_rdata1"}, rdata1, 0);
    endtask

    // Transaction-level reference: one transfer at a time, fixed latency, round-robin ties.
    always @(negedge clk) begin : model
        tx_t t;
        bit  w;
        if (reset) begin
            exp_q0.delete();
            exp_q1.delete();
            cur_valid = 1'b0;
            m_free    = 0;
            m_last    = 1'b1;
            m_rd[0]   = '0;
            m_rd[1]   = '0;
        end else if (cyc >= m_free && (req0 || req1)) begin
`ifdef ES_PRIORIDAD_FIJA_EN
            w = req0 ? 1'b0 : 1'b1;
`else
            if (req0 && req1) w = !m_last;
            else              w = req1;
`endif
            t.port    = w;
            t.we      = w ? we1 : we0;
            t.dir     = w ? dir1 : dir0;
            t.dato    = w ? dato1 : dato0;
            t.err     = int'(t.dir) >= ND;
            t.start   = cyc;
            t.ack_cyc = cyc + (t.err ? 2 : AC + 2);
            if (!t.we) m_rd[w] = t.err ? '0 : io_mem[t.dir];
            t.rd0     = m_rd[0];
            t.rd1     = m_rd[1];
            if (w) exp_q1.push_back(t);
            else   exp_q0.push_back(t);
            m_last    = w;
            m_free    = t.ack_cyc + 1;
            cur       = t;
            cur_valid = 1'b1;
        end
    end

    task automatic compara_ack(input string nom, input tx_t t, input logic e);
        chk({nom, "_ciclo"}, cyc, t.ack_cyc);
        chk({nom, "_err"}, e, t.err);
        chk({nom, "_rdata0"}, rdata0, t.rd0);
        chk({nom, "_rdata1"}, rdata1, t.rd1);
    endtask

    always @(negedge clk) begin : monitor
        tx_t t;
        bit  e_busy, e_act, e_bus;
        #2;
        e_busy = cur_valid && cyc > cur.start && cyc <= cur.ack_cyc;
        e_act  = cur_valid && !cur.err && cyc >= cur.start + 2 && cyc <= cur.start + AC + 1;
        e_bus  = cur_valid && cyc > cur.start && cyc < cur.ack_cyc;
        chk("busy", busy, e_busy);
        chk("activar", activar, e_act);
        chk("escribir", escribir, e_bus && cur.we);
        chk("direccion", direccion, e_bus ? cur.dir : 0);
        if (!e_bus || cur.we) chk("entrada", entrada, e_bus ? cur.dato : 0);
        if (ack0) begin
            if (exp_q0.size() == 0) begin
                nvec++;
                nfail++;
                $display("FAIL ack0: pulse at cycle %0d, required none", cyc);
            end else begin
                t = exp_q0.pop_front();
                compara_ack("ack0", t, err0);
            end
        end else begin
            chk("err0_sin_ack", err0, 0);
        end
        if (ack1) begin
            if (exp_q1.size() == 0) begin
                nvec++;
                nfail++;
                $display("FAIL ack1: pulse at cycle %0d, required none", cyc);
            end else begin
                t = exp_q1.pop_front();
                compara_ack("ack1", t, err1);
            end
        end else begin
            chk("err1_sin_ack", err1, 0);
        end
    end

    task automatic wait_ack(input bit p, input int limite);
        bit got;
        got = 1'b0;
        for (int i = 0; i < limite && !got; i++) begin
            @(negedge clk);
            got = p ? ack1 : ack0;
        end
        if (!got) begin
            nvec++;
            nfail++;
            $display("FAIL espera_ack%0d: no ack within %0d cycles, required one", p, limite);
        end
    endtask

    task automatic do_txn(input bit p, input bit we, input logic [AW-1:0] d,
                          input logic [DW-1:0] v);
        @(posedge clk);
        #1;
        if (p) begin
            req1 = 1'b1; we1 = we; dir1 = d; dato1 = v;
        end else begin
            req0 = 1'b1; we0 = we; dir0 = d; dato0 = v;
        end
        wait_ack(p, 60);
        @(posedge clk);
        #1;
        if (p) req1 = 1'b0;
        else   req0 = 1'b0;
    endtask

    task automatic rand_port(input bit p);
        for (int k = 0; k < 40; k++) begin
            logic [AW-1:0] d;
            repeat ($urandom_range(0, 3)) @(posedge clk);
            d = ($urandom_range(0, 9) == 9) ? AW'($urandom) : AW'($urandom_range(0, 7));
            do_txn(p, 1'($urandom), d, DW'($urandom));
        end
    endtask

    initial begin : watchdog
        #300000;
        $display("FAIL watchdog: simulation still running, required completion");
        $fatal(1, "timeout");
    end

    initial begin : main
        int  order[$];
        int  exp_order[4];
        bit  got;
`ifdef ES_PRIORIDAD_FIJA_EN
        exp_order = '{0, 0, 0, 0};
`else
        exp_order = '{0, 1, 0, 1};
`endif
        foreach (io_mem[i]) io_mem[i] = DW'($urandom);
        io_mem[4] = 8'h3C;

        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        reset = 1'b0;

        do_txn(1'b0, 1'b1, 7'd2, 8'hA5);
        do_txn(1'b1, 1'b0, 7'd4, 8'h00);
        do_txn(1'b0, 1'b0, 7'd9, 8'h00);

        // Inputs changed after the latch must not affect the transfer in flight.
        @(posedge clk);
        #1;
        req0 = 1'b1; we0 = 1'b0; dir0 = 7'd3; dato0 = 8'h11;
        @(posedge clk);
        #1;
        req0 = 1'b0; we0 = 1'b1; dir0 = 7'd8; dato0 = 8'h77;
        wait_ack(1'b0, 20);

        @(posedge clk);
        #1;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        we0 = 1'b0; dir0 = 7'd1; we1 = 1'b1; dir1 = 7'd2; dato1 = 8'h5A;
        req0 = 1'b1; req1 = 1'b1;
        order.delete();
        for (int i = 0; i < 200 && order.size() < 4; i++) begin
            @(negedge clk);
            if (ack0) order.push_back(0);
            if (ack1) order.push_back(1);
        end
        @(posedge clk);
        #1;
        req0 = 1'b0; req1 = 1'b0;
        chk("rr_cuenta", order.size(), 4);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("rr_grant%0d", i), (i < order.size()) ? order[i] : 2, exp_order[i]);
        end

        @(posedge clk);
        #1;
        req0 = 1'b1; we0 = 1'b0; dir0 = 7'd1;
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            got = activar;
        end
        chk("abort_activar_visto", got, 1);
        #3;
        reset = 1'b1;
        #1;
        check_all_zero("reset_async");
        @(posedge clk);
        #1;
        req0 = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        do_txn(1'b0, 1'b0, 7'd1, 8'h00);

        fork
            rand_port(1'b0);
            rand_port(1'b1);
        join

        repeat (10) @(posedge clk);
        #1;
        chk("pendientes0", exp_q0.size(), 0);
        chk("pendientes1", exp_q1.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
